gf2_row_feeder: RTL

//   Upstream stage of the single-pass GF(2) systolic systemizer. Reads M rows of an
//   N-column matrix from a row memory and drives them into the processor array with

---
 rtl/gf2_sys_pkg.sv | 23 ++
 rtl/gf2_skew_line.sv | 38 +++
 rtl/gf2_row_feeder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/gf2_sys_pkg.sv
// ---------------------------------------------------------------------------
// gf2_sys_pkg
//   Shared definitions for the single-pass GF(2) systolic systemizer.
//   - Array op codes driven along each processor row (column 0 op_in is tied
//     to OP_PASS by the array top level).
//   - State encoding of the row feeder FSM.
// ---------------------------------------------------------------------------
package gf2_sys_pkg;

  localparam logic [1:0] OP_PASS  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_XOR   = 2'b10;
  localparam logic [1:0] OP_START = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/gf2_skew_line.sv
// ---------------------------------------------------------------------------
// gf2_skew_line
//   Fixed-length delay line of DEPTH registers, W bits wide. One instance per
//   array column gives that column its diagonal skew.
// Ports
//   clk    in  1   rising-edge clock
//   rst_n  in  1   asynchronous active-low clear of every stage
//   din    in  W   value entering the line this cycle
//   dout   out W   value that entered DEPTH cycles ago
// ---------------------------------------------------------------------------
module gf2_skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] stage;

  // Clearing every stage on reset guarantees no stray start/finish reaches
  // the array after an aborted run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/gf2_row_feeder.sv
// ---------------------------------------------------------------------------
// gf2_row_feeder
//   Reads M rows of an N-column GF(2) matrix from a row memory and feeds them
//   into the systolic array with diagonal skew (column j lags column j-1 by
//   one cycle). Row 0 carries start; after the last row N flush slots carry
//   finish so each processor shifts out its pivot register. done pulses once
//   the wavefront has left column N-1.
// Ports
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous active-low reset
//   go          in   1       start request, ignored while busy
//   rd_en       out  1       row-memory read strobe
//   rd_addr     out  ADDR_W  row index being read (holds when idle)
//   rd_data     in   N       row data, valid one cycle after rd_en
//   data_out    out  N       skewed data for each array column
//   start_out   out  N       skewed start for each array column
//   finish_out  out  N       skewed finish for each array column
//   busy        out  1       run in progress (through the done cycle)
//   done        out  1       one-cycle end-of-run pulse
// ---------------------------------------------------------------------------
module gf2_row_feeder
  import gf2_sys_pkg::*;
#(
  parameter int N      = 8,
  parameter int M      = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [N-1:0]      rd_data,
  output logic [N-1:0]      data_out,
  output logic [N-1:0]      start_out,
  output logic [N-1:0]      finish_out,
  output logic              busy,
  output logic              done
);

  localparam int               CW       = $clog2(N + 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(M - 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(N);

  feeder_state_t     state, next_state;
  logic [ADDR_W-1:0] row_cnt;
  logic [CW-1:0]     cnt;
  logic              row_vld_q;
  logic              first_q;
  logic              fin_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FLUSH and DRAIN each run for N+1 counts (0..N). The extra count in each
  // phase absorbs the one-cycle memory latency and the output register, so
  // done lands two cycles after the last finish leaves column N-1. The last
  // FLUSH count is a bubble: finish is only raised for counts 0..N-1.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (go) next_state = FETCH;
      FETCH:   if (row_cnt == LAST_ROW) next_state = FLUSH;
      FLUSH:   if (cnt == CNT_LAST) next_state = DRAIN;
      DRAIN:   if (cnt == CNT_LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Row counter doubles as the read address; it only restarts on an
  // accepted go, so the address holds its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      cnt     <= '0;
    end else begin
      if (state == IDLE && go) begin
        row_cnt <= '0;
      end else if (state == FETCH && row_cnt != LAST_ROW) begin
        row_cnt <= row_cnt + ADDR_W'(1);
      end
      if ((state == FLUSH || state == DRAIN) && cnt != CNT_LAST) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  // Qualifiers delayed by one cycle so they line up with rd_data; row data is
  // gated so memory output outside a read slot never enters the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_vld_q <= 1'b0;
      first_q   <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      row_vld_q <= (state == FETCH);
      first_q   <= (state == FETCH) && (row_cnt == '0);
      fin_q     <= (state == FLUSH) && (cnt != CNT_LAST);
    end
  end

  assign rd_en   = (state == FETCH);
  assign rd_addr = row_cnt;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  for (genvar j = 0; j < N; j++) begin : g_col
    logic [2:0] lane_out;

    gf2_skew_line #(
      .DEPTH (j + 1),
      .W     (3)
    ) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .din   ({rd_data[j] & row_vld_q, first_q, fin_q}),
      .dout  (lane_out)
    );

    assign data_out[j]   = lane_out[2];
    assign start_out[j]  = lane_out[1];
    assign finish_out[j] = lane_out[0];
  end

endmodule
